bit_deserializer16: RTL and testbench
=====================================

# bit_deserializer16

Serial-to-parallel assembler: accepts one bit per cycle over a valid/ready handshake, steers each bit into its position of a 16-bit word through an internal 1:16 write decoder (LSB first), and presents the completed word on a registered valid/ready output port. It is the receiving end of bit-serial links in the pipelined processor, the counterpart of 16:1 bit selection. A holding register lets the next word's bits be accepted while the previous word waits to be consumed.

## Interface
- WIDTH, 16, word width; fixed at 16 in this revision.
- CNT_W, 4, width of the bit-position counter (log2 WIDTH).

- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- clear  input  1  synchronous abort of the partial word in assembly
- in_bit  input  1  serial data bit
- in_valid  input  1  in_bit is valid this cycle
- in_ready  output  1  block accepts in_bit this cycle (combinational)
- out_word  output  16  assembled word (registered)
- out_valid  output  1  out_word holds an unconsumed word (registered)
- out_ready  input  1  consumer takes out_word this cycle
- bit_count  output  4  number of bits of the current partial word (registered)

## Operation
- State: assembly register asm[15:0], position counter cnt[3:0], output register out_word, flag out_valid.
- Input accept: acc = in_valid & in_ready & ~clear.
- in_ready = ~(cnt==15 & out_valid & ~out_ready). Stalls only when the 16th bit would complete a word while the output slot is full and not draining.
- On acc with cnt<15: asm[cnt] <= in_bit; cnt <= cnt+1. Other asm bits are unchanged.
- On acc with cnt==15, word completion: out_word <= {in_bit, asm[14:0]}; out_valid <= 1; cnt wraps to 0. asm need not be cleared, because every position is rewritten before the next completion.
- Output drain: out_valid & out_ready with no completion in the same cycle sets out_valid <= 0. out_word holds its last value.
- Drain and completion in the same cycle: the new word loads and out_valid stays 1. This is back-to-back, bubble-free.
- clear: sets cnt <= 0; any in_bit offered that cycle is dropped. out_word and out_valid are unaffected, and a pending output drain still proceeds. clear wins over acc.
- reset has priority over everything. It sets cnt=0, asm=0, out_word=0, out_valid=0, giving bit_count=0. With out_valid=0, in_ready is therefore 1 in the cycle after reset.
- bit_count = cnt.

## Timing
- Latency: out_valid rises in the cycle after the 16th bit is accepted. out_word is valid in that same cycle.
- Throughput: 1 bit/cycle sustained, so one word every 16 cycles, provided out_ready is asserted at least once per 16 cycles.
- Backpressure: when out_valid=1 and out_ready=0, up to 15 bits of the next word are still accepted. Only bit 16 stalls (in_ready=0). bit 16 is taken in the first cycle out_ready=1.
- in_valid may be deasserted at any time. Gaps do not disturb cnt or asm.
- out_word and out_valid must not change while out_valid=1 and out_ready=0.
- Reset asserted mid-word or with an output pending: all state returns to reset values on the next edge. The partial word and the pending word are both lost.

## Test plan
- Reset state: hold reset 2 cycles, then release -> out_valid=0, out_word=0x0000, bit_count=0, in_ready=1.
- Single word: with out_ready=1, stream 0xA5C3 LSB first for 16 consecutive cycles -> out_valid=1 for exactly one cycle, one cycle after the last bit, with out_word=0xA5C3. bit_count runs 0..15 and then returns to 0.
- Back-to-back with gaps: send 0x0001, then 0x8000 with in_valid low on every 3rd cycle, out_ready=1 -> two words arrive in order, 0x0001 then 0x8000. No bit is lost or duplicated.
- Backpressure: send 0xFFFF with out_ready=0, then 15 bits of 0x1234 -> all 15 bits accepted. At the 16th bit, in_ready=0 and out_word stays 0xFFFF. Raise out_ready for 1 cycle -> 0xFFFF consumed, the 16th bit accepted, and the next cycle shows out_word=0x1234 with out_valid=1.
- Clear: send 5 bits, assert clear together with in_valid, then send 0x00F0 -> out_word=0x00F0. bit_count reads 0 after clear, and the bit offered during clear is discarded.
- Mid-operation reset: with out_valid=1 and 7 bits of a partial word in assembly, pulse reset -> next cycle out_valid=0, out_word=0, bit_count=0. A fresh 0x5A5A then assembles correctly.

Source files
------------

// File: rtl/bit_deserializer16_if.sv
// Handshake bundle for the serial-to-parallel assembler: bit input side,
// word output side and the partial-word position readback.
interface bit_deserializer16_if;
    logic        in_bit;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_word;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  bit_count;

    modport slave (
        input  in_bit, in_valid, out_ready,
        output in_ready, out_word, out_valid, bit_count
    );

    modport master (
        output in_bit, in_valid, out_ready,
        input  in_ready, out_word, out_valid, bit_count
    );
endinterface

// File: rtl/bit_deserializer16.sv
// 16-bit LSB-first bit-serial assembler with a one-word output holding register,
// so the next word keeps assembling while the previous one waits for the consumer.
module bit_deserializer16 #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  clear_i,
    bit_deserializer16_if.slave   bus
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] asm_q, asm_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] out_word_q, out_word_d;
    logic             out_valid_q, out_valid_d;

    logic             in_ready_c;
    logic             acc_c;
    logic             complete_c;
    logic             drain_c;
    logic [WIDTH-1:0] wr_sel_c;

    // Only the word-completing bit has to wait for a free output slot.
    assign in_ready_c = !((cnt_q == LAST) && out_valid_q && !bus.out_ready);
    assign acc_c      = bus.in_valid && in_ready_c && !clear_i;
    assign complete_c = acc_c && (cnt_q == LAST);
    assign drain_c    = out_valid_q && bus.out_ready;

    always_comb begin
        wr_sel_c    = '0;
        asm_d       = asm_q;
        cnt_d       = cnt_q;
        out_word_d  = out_word_q;
        out_valid_d = out_valid_q;

        if (acc_c && !complete_c) begin
            wr_sel_c = WIDTH'(1) << cnt_q;
        end
        asm_d = (asm_q & ~wr_sel_c) | ({WIDTH{bus.in_bit}} & wr_sel_c);

        if (clear_i || complete_c) begin
            cnt_d = '0;
        end else if (acc_c) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // The last bit bypasses asm and lands straight in the output register.
        if (complete_c) begin
            out_word_d  = {bus.in_bit, asm_q[WIDTH-2:0]};
            out_valid_d = 1'b1;
        end else if (drain_c) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            asm_q       <= '0;
            cnt_q       <= '0;
            out_word_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            asm_q       <= asm_d;
            cnt_q       <= cnt_d;
            out_word_q  <= out_word_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_word  = out_word_q;
    assign bus.out_valid = out_valid_q;
    assign bus.bit_count = cnt_q;
endmodule

// File: tb/tb_bit_deserializer16.sv
// Randomised and directed bench for bit_deserializer16, checked every cycle
// against a queue-based model of the accepted bit stream.
module tb_bit_deserializer16;
    logic clk;
    logic reset_i;
    logic clear_i;

    bit_deserializer16_if bus ();

    bit_deserializer16 dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .clear_i (clear_i),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: bits of the current partial word, and the output slot.
    logic        part_q[$];
    logic        m_valid = 1'b0;
    logic [15:0] m_word  = '0;
    logic        last_acc;
    logic [15:0] drained[$];
    int          gap_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic c, input logic b, input logic v, input logic o);
        logic        exp_rdy;
        logic        acc;
        logic        complete;
        logic [15:0] w;
        reset_i       = r;
        clear_i       = c;
        bus.in_bit    = b;
        bus.in_valid  = v;
        bus.out_ready = o;
        #2;
        exp_rdy = !(part_q.size() == 15 && m_valid && !o);
        if (!r) chk("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_rdy});
        if (!r && bus.out_valid === 1'b1 && o) drained.push_back(bus.out_word);

        acc      = 1'b0;
        complete = 1'b0;
        w        = '0;
        if (r) begin
            part_q.delete();
            m_valid = 1'b0;
            m_word  = '0;
        end else begin
            acc = v && exp_rdy && !c;
            if (c) begin
                part_q.delete();
            end else if (acc) begin
                part_q.push_back(b);
                if (part_q.size() == 16) begin
                    for (int i = 0; i < 16; i++) w[i] = part_q[i];
                    part_q.delete();
                    complete = 1'b1;
                end
            end
            if (complete) begin
                m_valid = 1'b1;
                m_word  = w;
            end else if (m_valid && o) begin
                m_valid = 1'b0;
            end
        end
        last_acc = acc;

        @(posedge clk);
        #1;
        chk("out_valid", {31'd0, bus.out_valid}, {31'd0, m_valid});
        chk("out_word",  {16'd0, bus.out_word},  {16'd0, m_word});
        chk("bit_count", {28'd0, bus.bit_count}, 32'(part_q.size()));
    endtask

    task automatic send_bit(input logic b, input logic o);
        int t;
        last_acc = 1'b0;
        t = 0;
        while (!last_acc && t < 40) begin
            step(1'b0, 1'b0, b, 1'b1, o);
            t++;
        end
        if (!last_acc) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_word(input logic [15:0] w, input logic o, input logic gaps);
        for (int i = 0; i < 16; i++) begin
            if (gaps) begin
                gap_cyc++;
                if (gap_cyc % 3 == 0) step(1'b0, 1'b0, ~w[i], 1'b0, o);
            end
            send_bit(w[i], o);
        end
    endtask

    initial begin
        logic [15:0] wbp;
        reset_i = 1'b1;
        clear_i = 1'b0;
        bus.in_bit = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_word",  {16'd0, bus.out_word},  32'd0);
        chk("rst_count", {28'd0, bus.bit_count}, 32'd0);
        chk("rst_ready", {31'd0, bus.in_ready},  32'd1);

        // Single word, then one-cycle out_valid
        send_word(16'hA5C3, 1'b1, 1'b0);
        chk("single_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("single_word",  {16'd0, bus.out_word},  32'hA5C3);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("single_drop", {31'd0, bus.out_valid}, 32'd0);

        // Back-to-back with gaps
        drained.delete();
        send_word(16'h0001, 1'b1, 1'b1);
        send_word(16'h8000, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("b2b_n", 32'(drained.size()), 32'd2);
        chk("b2b_w0", {16'd0, drained.size() > 0 ? drained[0] : 16'hxxxx}, 32'h0001);
        chk("b2b_w1", {16'd0, drained.size() > 1 ? drained[1] : 16'hxxxx}, 32'h8000);

        // Backpressure
        wbp = 16'h1234;
        send_word(16'hFFFF, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) send_bit(wbp[i], 1'b0);
        step(1'b0, 1'b0, wbp[15], 1'b1, 1'b0);
        step(1'b0, 1'b0, wbp[15], 1'b1, 1'b0);
        chk("bp_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("bp_hold",  {16'd0, bus.out_word}, 32'hFFFF);
        chk("bp_count", {28'd0, bus.bit_count}, 32'd15);
        step(1'b0, 1'b0, wbp[15], 1'b1, 1'b1);
        chk("bp_word",  {16'd0, bus.out_word},  32'h1234);
        chk("bp_valid", {31'd0, bus.out_valid}, 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Clear
        for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(1)), 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("clr_count", {28'd0, bus.bit_count}, 32'd0);
        send_word(16'h00F0, 1'b1, 1'b0);
        chk("clr_word", {16'd0, bus.out_word}, 32'h00F0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Mid-operation reset
        send_word(16'hBEEF, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) send_bit(1'($urandom_range(1)), 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("mrst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("mrst_word",  {16'd0, bus.out_word},  32'd0);
        chk("mrst_count", {28'd0, bus.bit_count}, 32'd0);
        send_word(16'h5A5A, 1'b1, 1'b0);
        chk("mrst_fresh", {16'd0, bus.out_word}, 32'h5A5A);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(199) == 0,
                 $urandom_range(19) == 0,
                 1'($urandom_range(1)),
                 $urandom_range(3) != 0,
                 $urandom_range(2) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
